// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Two-source (ALU / LSU) FIFO-buffered arbiter for the single
//            register-file write port, with pending-write mask for hazards.
//            Optional macro RF_ARB_ROUND_ROBIN_EN: alternate grants on contention.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [AW-1:0]        s0_addr,
    input  logic [DW-1:0]        s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [AW-1:0]        s1_addr,
    input  logic [DW-1:0]        s1_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [(2**AW)-1:0]   pend_mask,
    output logic                 idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fifo_addr_q [2][DEPTH];
    logic [DW-1:0] fifo_data_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] count_q  [2];
    logic [CW-1:0] count_d  [2];

    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;

    logic [1:0]    in_valid;
    logic [AW-1:0] in_addr [2];
    logic [DW-1:0] in_data [2];
    logic [1:0]    ready;
    logic [1:0]    nonempty;
    logic [1:0]    push;
    logic [1:0]    grant;
    logic          head_sel;
    logic [PW-1:0] pend_off;

    assign in_valid   = {s1_valid, s0_valid};
    assign in_addr[0] = s0_addr;
    assign in_addr[1] = s1_addr;
    assign in_data[0] = s0_data;
    assign in_data[1] = s1_data;

    // x0 requests are handshaken normally but never reach the FIFO.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ready[p]    = (count_q[p] != CW'(DEPTH));
            nonempty[p] = (count_q[p] != '0);
            push[p]     = in_valid[p] & ready[p] & (in_addr[p] != '0);
        end
    end

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_comb begin
        grant = nonempty;
        if (&nonempty) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if (&nonempty) begin
            last_grant_q <= grant[1];
        end
    end
`else
    always_comb begin
        grant = nonempty;
        if (&nonempty) begin
            grant = 2'b10;
        end
    end
`endif

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + PW'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PW'(grant[p]);
            count_d[p]  = count_q[p] + CW'(push[p]) - CW'(grant[p]);
        end
    end

    assign head_sel = grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                count_q[p]  <= count_d[p];
            end
            rf_we_q <= |grant;
            if (|grant) begin
                rf_waddr_q <= fifo_addr_q[head_sel][rd_ptr_q[head_sel]];
                rf_wdata_q <= fifo_data_q[head_sel][rd_ptr_q[head_sel]];
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifo_addr_q[p][wr_ptr_q[p]] <= in_addr[p];
                fifo_data_q[p][wr_ptr_q[p]] <= in_data[p];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        pend_off  = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_off = PW'(i) - rd_ptr_q[p];
                if (CW'(pend_off) < count_q[p]) begin
                    pend_mask[fifo_addr_q[p][i]] = 1'b1;
                end
            end
        end
        if (rf_we_q) begin
            pend_mask[rf_waddr_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign s0_ready = ready[0];
    assign s1_ready = ready[1];
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign idle     = ~(|nonempty) & ~rf_we_q;

endmodule
`default_nettype wire
